// File: rtl/synth_pkg.sv
// Shared types and helpers for the voice mixer: state enum, envelope unity, widths, saturation.
// Latency: none (package only).
// Backpressure: none (package only).
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int ENV_W_DEFAULT = 9;
  localparam int ENV_ONE       = 1 << (ENV_W_DEFAULT - 1);

  // Accumulator wide enough that NCH full-scale sample*gain terms cannot overflow.
  function automatic int acc_width(input int w, input int gw, input int nch);
    return w + gw + $clog2(nch) + 1;
  endfunction

  // Clamp x into the signed w-bit range; clipped reports whether clamping happened.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int w,
                                                  output logic clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi       = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo       = -(64'sd1 <<< (w - 1));
    clipped  = 1'b0;
    saturate = x;
    if (x > hi) begin
      saturate = hi;
      clipped  = 1'b1;
    end else if (x < lo) begin
      saturate = lo;
      clipped  = 1'b1;
    end
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Sample-strobe bus between the oscillator bank / control and the mixer.
// Latency: none (wiring only).
// Backpressure: none; strobes arriving while the mixer is busy are flagged by overrun.
interface voice_mixer_if #(
  parameter int NCH = 4,
  parameter int W   = 16,
  parameter int GW  = 4
);

  logic              sample_stb;
  logic [NCH*W-1:0]  ch_in;
  logic [NCH-1:0]    ch_en;
  logic [NCH*GW-1:0] ch_gain;
  logic              gate;
  logic [W-1:0]      out_sample;
  logic              out_valid;
  logic              clip;
  logic              overrun;
  logic              busy;

  modport master (
    output sample_stb, ch_in, ch_en, ch_gain, gate,
    input  out_sample, out_valid, clip, overrun, busy
  );

  modport slave (
    input  sample_stb, ch_in, ch_en, ch_gain, gate,
    output out_sample, out_valid, clip, overrun, busy
  );

endinterface

// File: rtl/env_ramp.sv
// Linear gate-driven envelope, clamped to [0, ONE], moved by STEP once per step_en.
// Latency: new envelope visible the cycle after step_en.
// Backpressure: none; holds its value whenever step_en is low.
import synth_pkg::*;

module env_ramp #(
  parameter int ENV_W = ENV_W_DEFAULT,
  parameter int ONE   = ENV_ONE,
  parameter int STEP  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic             gate,
  output logic [ENV_W-1:0] env
);

  localparam logic [ENV_W:0] ONE_X  = (ENV_W + 1)'(ONE);
  localparam logic [ENV_W:0] STEP_X = (ENV_W + 1)'(STEP);

  logic [ENV_W:0]   env_up;
  logic [ENV_W-1:0] env_nxt;

  // Next envelope: saturating climb toward unity while gated, saturating fall to zero otherwise.
  always_comb begin
    env_up  = {1'b0, env} + STEP_X;
    env_nxt = env;
    if (gate) begin
      env_nxt = (env_up >= ONE_X) ? ONE_X[ENV_W-1:0] : env_up[ENV_W-1:0];
    end else begin
      env_nxt = ({1'b0, env} < STEP_X) ? '0 : (env - STEP_X[ENV_W-1:0]);
    end
  end

  // Envelope register, advanced only when the mixer publishes a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env <= '0;
    end else if (step_en) begin
      env <= env_nxt;
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed NCH-channel gain mixer with envelope scaling and W-bit saturation.
// Latency: sample_stb in cycle 0 gives out_valid in cycle NCH+3.
// Backpressure: none; a strobe while busy is dropped and reported on overrun.
import synth_pkg::*;

module voice_mixer #(
  parameter int NCH       = 4,
  parameter int W         = 16,
  parameter int GW        = 4,
  parameter int ENV_W     = 9,
  parameter int RAMP_STEP = 16
) (
  input logic         clk,
  input logic         rst_n,
  voice_mixer_if.slave bus
);

  localparam int ACC_W  = acc_width(W, GW, NCH);
  localparam int IDX_W  = $clog2(NCH);
  localparam int TW     = W + GW + 1;
  localparam int PROD_W = ACC_W + ENV_W + 1;

  state_t state;
  state_t state_nxt;

  logic [NCH*W-1:0]        snap_in;
  logic [NCH-1:0]          snap_en;
  logic [NCH*GW-1:0]       snap_gain;
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;
  logic [W-1:0]            res_r;
  logic                    clip_r;
  logic [ENV_W-1:0]        env;

  logic signed [W-1:0]      cur_smp;
  logic [GW-1:0]            cur_gain;
  logic signed [TW-1:0]     term;
  logic signed [ACC_W-1:0]  acc_add;
  logic signed [ACC_W-1:0]  mix;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] res;
  logic signed [63:0]       sat;
  logic                     sat_clip;

  assign bus.busy = (state != IDLE);

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sequencer: one accumulate cycle per channel, then scale, then publish.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sample_stb) state_nxt = ACCUM;
      ACCUM:   if (idx == IDX_W'(NCH - 1)) state_nxt = SCALE;
      SCALE:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: current channel term, floor-shifted mix, envelope product and saturation.
  always_comb begin
    cur_smp  = snap_in[W*int'(idx) +: W];
    cur_gain = snap_gain[GW*int'(idx) +: GW];
    term     = TW'(cur_smp) * TW'($signed({1'b0, cur_gain}));
    acc_add  = acc + ACC_W'(term);
    mix      = acc >>> GW;
    prod     = PROD_W'(mix) * PROD_W'($signed({1'b0, env}));
    res      = prod >>> (ENV_W - 1);
    sat_clip = 1'b0;
    sat      = saturate(64'(res), W, sat_clip);
  end

  // Snapshot on accepted strobe, accumulate enabled channels, latch the saturated result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_in   <= '0;
      snap_en   <= '0;
      snap_gain <= '0;
      acc       <= '0;
      idx       <= '0;
      res_r     <= '0;
      clip_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sample_stb) begin
            snap_in   <= bus.ch_in;
            snap_en   <= bus.ch_en;
            snap_gain <= bus.ch_gain;
            acc       <= '0;
            idx       <= '0;
          end
        end
        ACCUM: begin
          if (snap_en[idx]) acc <= acc_add;
          idx <= (idx == IDX_W'(NCH - 1)) ? '0 : idx + IDX_W'(1);
        end
        SCALE: begin
          res_r  <= sat[W-1:0];
          clip_r <= sat_clip;
        end
        default: ;
      endcase
    end
  end

  // Output registers: sample held between updates, clip only alongside out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_sample <= '0;
      bus.out_valid  <= 1'b0;
      bus.clip       <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.out_valid <= (state == OUT);
      bus.clip      <= (state == OUT) ? clip_r : 1'b0;
      bus.overrun   <= bus.sample_stb && (state != IDLE);
      if (state == OUT) bus.out_sample <= res_r;
    end
  end

  env_ramp #(
    .ENV_W (ENV_W),
    .ONE   (1 << (ENV_W - 1)),
    .STEP  (RAMP_STEP)
  ) u_env (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_en (state == OUT),
    .gate    (bus.gate),
    .env     (env)
  );

endmodule
